// File: rtl/id_ex_latch.sv
// id_ex_latch: decode->execute pipeline register of the 5-stage MIPS pipeline.
// Captures decoded controls, operands, immediates and register IDs on enabled
// cycles, holds on stall, loads an all-zero bubble on flush, and freezes once
// a valid halt instruction has been captured.
// Optional feature macro: ID_EX_BUBBLE_CNT_EN adds a saturating count of
// flush-inserted bubbles on bubble_cnt_o; without it the port is tied to 0.
module id_ex_latch #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 en,
    input  logic                 flush,
    input  logic [WORD_W-1:0]    nPC_i,
    input  logic [WORD_W-1:0]    instr_i,
    input  logic [WORD_W-1:0]    rdat1_i,
    input  logic [WORD_W-1:0]    rdat2_i,
    input  logic [WORD_W-1:0]    imm_i,
    input  logic [WORD_W-1:0]    lui_i,
    input  logic [4:0]           shamt_i,
    input  logic [3*REG_W-1:0]   regs_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    output logic [WORD_W-1:0]    nPC_o,
    output logic [WORD_W-1:0]    instr_o,
    output logic [WORD_W-1:0]    rdat1_o,
    output logic [WORD_W-1:0]    rdat2_o,
    output logic [WORD_W-1:0]    imm_o,
    output logic [WORD_W-1:0]    lui_o,
    output logic [4:0]           shamt_o,
    output logic [3*REG_W-1:0]   regs_o,
    output logic [CTRL_W-1:0]    ctrl_o,
    output logic                 valid_o,
    output logic                 halt_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    logic [WORD_W-1:0]  npc_q,   npc_d;
    logic [WORD_W-1:0]  instr_q, instr_d;
    logic [WORD_W-1:0]  rdat1_q, rdat1_d;
    logic [WORD_W-1:0]  rdat2_q, rdat2_d;
    logic [WORD_W-1:0]  imm_q,   imm_d;
    logic [WORD_W-1:0]  lui_q,   lui_d;
    logic [4:0]         shamt_q, shamt_d;
    logic [3*REG_W-1:0] regs_q,  regs_d;
    logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
    logic               valid_q, valid_d;
    logic               halt_q,  halt_d;
    logic               bubble_load;

    // Next-state selection: frozen > flush > en > hold.
    always_comb begin
        npc_d       = npc_q;
        instr_d     = instr_q;
        rdat1_d     = rdat1_q;
        rdat2_d     = rdat2_q;
        imm_d       = imm_q;
        lui_d       = lui_q;
        shamt_d     = shamt_q;
        regs_d      = regs_q;
        ctrl_d      = ctrl_q;
        valid_d     = valid_q;
        halt_d      = halt_q;
        bubble_load = 1'b0;
        if (!halt_q) begin
            if (flush) begin
                // All-zero bubble: ctrl 0 disables writes/memory, instr 0 is sll $0.
                npc_d       = '0;
                instr_d     = '0;
                rdat1_d     = '0;
                rdat2_d     = '0;
                imm_d       = '0;
                lui_d       = '0;
                shamt_d     = '0;
                regs_d      = '0;
                ctrl_d      = '0;
                valid_d     = 1'b0;
                bubble_load = 1'b1;
            end else if (en) begin
                npc_d   = nPC_i;
                instr_d = instr_i;
                rdat1_d = rdat1_i;
                rdat2_d = rdat2_i;
                imm_d   = imm_i;
                lui_d   = lui_i;
                shamt_d = shamt_i;
                regs_d  = regs_i;
                ctrl_d  = ctrl_i;
                valid_d = 1'b1;
                halt_d  = ctrl_i[0];
            end
        end
    end

    // Pipeline register state with asynchronous clear to a bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            npc_q   <= '0;
            instr_q <= '0;
            rdat1_q <= '0;
            rdat2_q <= '0;
            imm_q   <= '0;
            lui_q   <= '0;
            shamt_q <= '0;
            regs_q  <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            npc_q   <= npc_d;
            instr_q <= instr_d;
            rdat1_q <= rdat1_d;
            rdat2_q <= rdat2_d;
            imm_q   <= imm_d;
            lui_q   <= lui_d;
            shamt_q <= shamt_d;
            regs_q  <= regs_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating bubble count, advanced only on flush-loaded bubbles.
    always_comb begin
        cnt_d = cnt_q;
        if (bubble_load) cnt_d = sat_inc(cnt_q);
    end

    // Bubble counter register, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bubble_cnt_o = cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_load;
    assign bubble_cnt_o  = '0;
`endif

    assign nPC_o   = npc_q;
    assign instr_o = instr_q;
    assign rdat1_o = rdat1_q;
    assign rdat2_o = rdat2_q;
    assign imm_o   = imm_q;
    assign lui_o   = lui_q;
    assign shamt_o = shamt_q;
    assign regs_o  = regs_q;
    assign ctrl_o  = ctrl_q;
    assign valid_o = valid_q;
    assign halt_o  = halt_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: reset, capture, stall, flush, halt freeze
// and (when ID_EX_BUBBLE_CNT_EN is defined) the saturating bubble counter.
module tb_id_ex_latch;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        en, flush;
    logic [31:0] nPC_i, instr_i, rdat1_i, rdat2_i, imm_i, lui_i;
    logic [4:0]  shamt_i;
    logic [14:0] regs_i;
    logic [11:0] ctrl_i;
    logic [31:0] nPC_o, instr_o, rdat1_o, rdat2_o, imm_o, lui_o;
    logic [4:0]  shamt_o;
    logic [14:0] regs_o;
    logic [11:0] ctrl_o;
    logic        valid_o, halt_o;
    logic [15:0] bubble_cnt_o;

    // Second instance with a 2-bit counter for saturation; only its counter is checked.
    logic [31:0] s_npc, s_instr, s_r1, s_r2, s_imm, s_lui;
    logic [4:0]  s_sh;
    logic [14:0] s_regs;
    logic [11:0] s_ctrl;
    logic        s_valid, s_halt;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    id_ex_latch dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .nPC_i(nPC_i), .instr_i(instr_i), .rdat1_i(rdat1_i), .rdat2_i(rdat2_i),
        .imm_i(imm_i), .lui_i(lui_i), .shamt_i(shamt_i), .regs_i(regs_i), .ctrl_i(ctrl_i),
        .nPC_o(nPC_o), .instr_o(instr_o), .rdat1_o(rdat1_o), .rdat2_o(rdat2_o),
        .imm_o(imm_o), .lui_o(lui_o), .shamt_o(shamt_o), .regs_o(regs_o), .ctrl_o(ctrl_o),
        .valid_o(valid_o), .halt_o(halt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_latch #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .nPC_i(nPC_i), .instr_i(instr_i), .rdat1_i(rdat1_i), .rdat2_i(rdat2_i),
        .imm_i(imm_i), .lui_i(lui_i), .shamt_i(shamt_i), .regs_i(regs_i), .ctrl_i(ctrl_i),
        .nPC_o(s_npc), .instr_o(s_instr), .rdat1_o(s_r1), .rdat2_o(s_r2),
        .imm_o(s_imm), .lui_o(s_lui), .shamt_o(s_sh), .regs_o(s_regs), .ctrl_o(s_ctrl),
        .valid_o(s_valid), .halt_o(s_halt), .bubble_cnt_o(s_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] base, input logic [11:0] c);
        nPC_i   = base + 32'h4;
        instr_i = base ^ 32'h0123_4567;
        rdat1_i = base + 32'h11;
        rdat2_i = base + 32'h22;
        imm_i   = base + 32'h33;
        lui_i   = {base[15:0], 16'h0};
        shamt_i = base[4:0] ^ 5'h15;
        regs_i  = base[14:0] ^ 15'h5A5A;
        ctrl_i  = c;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] base, input logic [11:0] c);
        logic [31:0] b;
        b = base;
        chk({tag, "_npc"},   nPC_o,   b + 32'h4);
        chk({tag, "_instr"}, instr_o, b ^ 32'h0123_4567);
        chk({tag, "_r1"},    rdat1_o, b + 32'h11);
        chk({tag, "_r2"},    rdat2_o, b + 32'h22);
        chk({tag, "_imm"},   imm_o,   b + 32'h33);
        chk({tag, "_lui"},   lui_o,   {b[15:0], 16'h0});
        chk({tag, "_shamt"}, shamt_o, b[4:0] ^ 5'h15);
        chk({tag, "_regs"},  regs_o,  b[14:0] ^ 15'h5A5A);
        chk({tag, "_ctrl"},  ctrl_o,  c);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_npc"},   nPC_o,   0);
        chk({tag, "_instr"}, instr_o, 0);
        chk({tag, "_r1"},    rdat1_o, 0);
        chk({tag, "_r2"},    rdat2_o, 0);
        chk({tag, "_imm"},   imm_o,   0);
        chk({tag, "_lui"},   lui_o,   0);
        chk({tag, "_shamt"}, shamt_o, 0);
        chk({tag, "_regs"},  regs_o,  0);
        chk({tag, "_ctrl"},  ctrl_o,  0);
        chk({tag, "_valid"}, valid_o, 0);
    endtask

    task automatic chk_cnt(input string tag, input int full, input int sat);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({tag, "_cnt"},    bubble_cnt_o, full);
        chk({tag, "_satcnt"}, s_cnt, sat);
`else
        chk({tag, "_cnt"},    bubble_cnt_o, 0);
        chk({tag, "_satcnt"}, s_cnt, 0);
        if (full < 0 || sat < 0) $display("note: negative count request");
`endif
    endtask

    initial begin
        nRST = 1'b0; en = 1'b0; flush = 1'b0;
        drive(32'h0, 12'h0);
        #12;
        chk_zero("rst");
        chk("rst_halt", halt_o, 0);
        chk_cnt("rst", 0, 0);

        // T2: capture a lw
        @(negedge CLK); nRST = 1'b1;
        @(negedge CLK);
        drive(32'h0, 12'hA00);
        instr_i = 32'h8C41_0004; rdat1_i = 32'h100; en = 1'b1;
        tick();
        chk("t2_instr", instr_o, 32'h8C41_0004);
        chk("t2_rdat1", rdat1_o, 32'h100);
        chk("t2_ctrl",  ctrl_o,  12'hA00);
        chk("t2_valid", valid_o, 1);
        chk("t2_halt",  halt_o,  0);

        // T3: capture A, stall 3 cycles with B on inputs, then capture B
        @(negedge CLK); drive(32'hA0A0_1000, 12'h2C4);
        tick();
        chk_all("t3a", 32'hA0A0_1000, 12'h2C4);
        @(negedge CLK); drive(32'h0B0B_2000, 12'h316); en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t3hold", 32'hA0A0_1000, 12'h2C4);
            chk("t3hold_valid", valid_o, 1);
        end
        @(negedge CLK); en = 1'b1;
        tick();
        chk_all("t3b", 32'h0B0B_2000, 12'h316);

        // T1: async reset mid-run clears before the next edge
        @(negedge CLK); #1 nRST = 1'b0; #1;
        chk_zero("t1");
        chk("t1_halt", halt_o, 0);
        @(negedge CLK); nRST = 1'b1;

        // T4: flush overrides capture
        @(negedge CLK); drive(32'h5555_0000, 12'h200); en = 1'b1; flush = 1'b1;
        tick();
        chk_zero("t4");
        chk_cnt("t4a", 1, 1);
        for (int i = 0; i < 3; i++) tick();
        chk_cnt("t4b", 4, 3);
        @(negedge CLK); en = 1'b0;
        tick();
        chk("t4_noen_valid", valid_o, 0);
        chk_cnt("t6", 5, 3);
        @(negedge CLK); flush = 1'b0;
        tick();
        chk("t4_stall_valid", valid_o, 0);
        chk_cnt("t4c", 5, 3);

        // T5: same-edge flush+halt, then real halt capture and freeze
        @(negedge CLK); drive(32'h7777_0000, 12'h001); en = 1'b1; flush = 1'b1;
        tick();
        chk("t5_fh_halt",  halt_o,  0);
        chk("t5_fh_valid", valid_o, 0);
        @(negedge CLK); flush = 1'b0;
        tick();
        chk("t5_halt",  halt_o,  1);
        chk("t5_valid", valid_o, 1);
        chk_all("t5cap", 32'h7777_0000, 12'h001);
        @(negedge CLK); drive(32'h1234_0000, 12'h200);
        tick();
        chk_all("t5frz_en", 32'h7777_0000, 12'h001);
        @(negedge CLK); flush = 1'b1;
        tick(); tick();
        chk_all("t5frz_fl", 32'h7777_0000, 12'h001);
        chk("t5frz_valid", valid_o, 1);
        chk("t5frz_halt",  halt_o,  1);
        chk_cnt("t5frz", 6, 3);
        @(negedge CLK); nRST = 1'b0; #1;
        chk("t5_rst_halt", halt_o, 0);
        chk_cnt("t5rst", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
